// File: rtl/tabchk_pkg.sv
// rtl/tabchk_pkg.sv - shared types, widths and the value table for the tabulated vector checker
// Purpose: FSM state enum, status field widths and value(lane, step), the formula that
//          defines what every lane carries on every issued step.
// Ports:   none (package).
package tabchk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int ERR_W      = 16;
  localparam int LANE_IDX_W = 4;
  localparam int STEP_W     = 16;

  // (lane + 1) + step*lanes, truncated to width bits (width up to 64).
  function automatic logic [63:0] value(input int unsigned lane, input int unsigned step,
                                        input int unsigned lanes, input int unsigned width);
    logic [63:0] raw;
    logic [63:0] mask;
    raw  = 64'(lane) + 64'd1 + 64'(step) * 64'(lanes);
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return raw & mask;
  endfunction

endpackage

// File: rtl/tabulate_vec_checker_if.sv
// rtl/tabulate_vec_checker_if.sv - lane vector bus between the checker and the lanes under test
// Purpose: bundles the issued vector and the returned vector with their valids.
// Ports:   lane_out/lane_out_valid (checker -> lanes), lane_in/lane_in_valid (lanes -> checker);
//          lane i occupies bits [i*WIDTH +: WIDTH] in both directions.
//          modport master = checker side, modport slave = lane side.
interface tabulate_vec_checker_if #(
  parameter int LANES = 3,
  parameter int WIDTH = 32
);
  logic [LANES*WIDTH-1:0] lane_out;
  logic                   lane_out_valid;
  logic [LANES*WIDTH-1:0] lane_in;
  logic                   lane_in_valid;

  modport master (output lane_out, output lane_out_valid, input lane_in, input lane_in_valid);
  modport slave  (input lane_out, input lane_out_valid, output lane_in, output lane_in_valid);
endinterface

// File: rtl/tabchk_exp_fifo.sv
// rtl/tabchk_exp_fifo.sv - expected-vector FIFO holding issued vectors until their responses return
// Purpose: synchronous FIFO, pointers carry one wrap bit, head is combinational (no read latency).
//          A push and a pop in the same cycle are allowed even when full.
// Ports:   clock, reset (sync, active low), clr_i (synchronous flush), push_i/wdata_i,
//          pop_i, head_o (oldest entry), full_o, empty_o, one_left_o (exactly one entry held).
module tabchk_exp_fifo #(
  parameter int DW    = 96,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          one_left_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q, level;

  // DEPTH is a power of two, so the level reaches DEPTH exactly when its top bit sets.
  assign level      = wptr_q - rptr_q;
  assign empty_o    = (level == '0);
  assign full_o     = level[AW];
  assign one_left_o = (level == (AW+1)'(1));
  assign head_o     = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/tabulate_vec_checker.sv
// rtl/tabulate_vec_checker.sv - issues tabulated lane vectors and checks the returned vectors
// Purpose: on start, issues STEPS vectors value(*, step) while the expected FIFO has room, pops
//          one expected vector per returned vector and compares lane by lane; reports pass,
//          a saturating error count, the first failing lane and a sticky unexpected flag.
// Config:  TABCHK_TIMEOUT_EN adds a response watchdog (TIMEOUT cycles) and the timed_out port.
// Ports:   clock, reset (sync, active low), start (one-cycle pulse), lanes (master side of the
//          lane bus), busy (RUN/DRAIN), done (DONE), pass (meaningful while done), err_count,
//          first_err_lane, unexpected, timed_out (watchdog build only).
module tabulate_vec_checker
  import tabchk_pkg::*;
#(
  parameter int LANES     = 3,
  parameter int WIDTH     = 32,
  parameter int STEPS     = 4,
  parameter int EXP_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  tabulate_vec_checker_if.master lanes,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [LANE_IDX_W-1:0] first_err_lane,
  output logic                  unexpected
`ifdef TABCHK_TIMEOUT_EN
  ,
  output logic                  timed_out
`endif
);
  localparam int VW = LANES * WIDTH;

  if (LANES < 1 || LANES > 16 || STEPS < 1 || STEPS > 65535 || EXP_DEPTH < 2 ||
      (EXP_DEPTH & (EXP_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("tabulate_vec_checker: parameter out of range");
  end

  state_e                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [VW-1:0]         out_q, out_d;
  logic                  vld_q, vld_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic [LANE_IDX_W-1:0] first_q, first_d;
  logic                  unexp_q, unexp_d;

  logic                  start_go, active, issue, pop, tmo_hit;
  logic                  fifo_full, fifo_empty, fifo_one;
  logic [VW-1:0]         head;
  logic [LANES-1:0]      mis;
  logic [LANE_IDX_W-1:0] low_idx;

`ifdef TABCHK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
`endif

  tabchk_exp_fifo #(.DW(VW), .DEPTH(EXP_DEPTH)) u_exp_fifo (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (start_go),
    .push_i     (issue),
    .wdata_i    (out_d),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .one_left_o (fifo_one)
  );

  always_comb begin
    start_go = start && (state_q == S_IDLE || state_q == S_DONE);
    active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    pop      = active && lanes.lane_in_valid && !fifo_empty;

    mis     = '0;
    low_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      mis[i] = head[i*WIDTH +: WIDTH] != lanes.lane_in[i*WIDTH +: WIDTH];
      if (mis[i]) low_idx = LANE_IDX_W'(i);
    end

    tmo_hit = 1'b0;
`ifdef TABCHK_TIMEOUT_EN
    // Watchdog only runs while a response is owed and none is arriving.
    wd_d = '0;
    if (active && !fifo_empty && !lanes.lane_in_valid) wd_d = wd_q + WD_W'(1);
    tmo_hit = active && (wd_d == WD_W'(TIMEOUT));
    to_d    = to_q | tmo_hit;
`endif

    // A same-cycle pop frees a slot, so a full FIFO does not stall issue then.
    issue = (state_q == S_RUN) && (!fifo_full || pop) && !tmo_hit;

    state_d = state_q;
    step_d  = step_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    first_d = first_q;
    unexp_d = unexp_q;

    if (issue) begin
      for (int i = 0; i < LANES; i++) begin
        out_d[i*WIDTH +: WIDTH] = WIDTH'(value(i, 32'(step_q), LANES, WIDTH));
      end
      vld_d  = 1'b1;
      step_d = step_q + STEP_W'(1);
      if (step_q == STEP_W'(STEPS - 1)) state_d = S_DRAIN;
    end

    if (pop && (mis != '0)) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) first_d = low_idx;
    end
    if (lanes.lane_in_valid && !pop) unexp_d = 1'b1;

    // Leave DRAIN in the same cycle the last owed response is consumed.
    if (state_q == S_DRAIN && (fifo_empty || (pop && fifo_one))) state_d = S_DONE;
    if (tmo_hit) state_d = S_DONE;

    if (start_go) begin
      state_d = S_RUN;
      step_d  = '0;
      err_d   = '0;
      first_d = '0;
      unexp_d = 1'b0;
`ifdef TABCHK_TIMEOUT_EN
      to_d = 1'b0;
      wd_d = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      unexp_q <= 1'b0;
`ifdef TABCHK_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      first_q <= first_d;
      unexp_q <= unexp_d;
`ifdef TABCHK_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign lanes.lane_out       = out_q;
  assign lanes.lane_out_valid = vld_q;
  assign busy                 = active;
  assign done                 = (state_q == S_DONE);
  assign err_count            = err_q;
  assign first_err_lane       = first_q;
  assign unexpected           = unexp_q;
`ifdef TABCHK_TIMEOUT_EN
  assign timed_out            = to_q;
  assign pass                 = done && (err_q == '0) && !unexp_q && !to_q;
`else
  assign pass                 = done && (err_q == '0) && !unexp_q;
`endif
endmodule

// File: tb/tb_tabulate_vec_checker.sv
// tb/tb_tabulate_vec_checker.sv - self-checking bench for tabulate_vec_checker
module tb_tabulate_vec_checker;
  localparam int L  = 3;
  localparam int W  = 32;
  localparam int S  = 6;
  localparam int D  = 2;
  localparam int VW = L * W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clock = ~clock;

  tabulate_vec_checker_if #(.LANES(L), .WIDTH(W)) bus ();

  logic        busy, done, pass, unexpected;
  logic [15:0] err_count;
  logic [3:0]  first_err_lane;
`ifdef TABCHK_TIMEOUT_EN
  logic        timed_out;
`endif

  tabulate_vec_checker #(.LANES(L), .WIDTH(W), .STEPS(S), .EXP_DEPTH(D), .TIMEOUT(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .lanes          (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_lane (first_err_lane),
    .unexpected     (unexpected)
`ifdef TABCHK_TIMEOUT_EN
    ,
    .timed_out      (timed_out)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Return path model: fixed latency dly, optional per-vector XOR corruption, withhold, injection.
  int            dly = 0;
  bit            withhold = 0;
  bit            inj = 0;
  bit            arm = 0;
  int            out_cnt = 0;
  logic [VW-1:0] cmask [S];
  logic [VW-1:0] cmask_cur;
  logic          pv [4];
  logic [VW-1:0] pd [4];
  logic          rv;

  always_comb cmask_cur = (out_cnt < S) ? cmask[out_cnt] : '0;

  always @(posedge clock) begin
    if (arm || !reset) begin
      out_cnt <= 0;
      for (int k = 0; k < 4; k++) pv[k] <= 1'b0;
    end else begin
      if (bus.lane_out_valid) out_cnt <= out_cnt + 1;
      pv[0] <= bus.lane_out_valid;
      pd[0] <= bus.lane_out ^ cmask_cur;
      for (int k = 1; k < 4; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  always_comb begin
    if (dly == 0) begin
      bus.lane_in = bus.lane_out ^ cmask_cur;
      rv          = bus.lane_out_valid;
    end else begin
      bus.lane_in = pd[dly-1];
      rv          = pv[dly-1];
    end
    bus.lane_in_valid = (rv & ~withhold) | inj;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every issued vector must equal the table for its issue index.
  always @(negedge clock) begin
    if (reset && bus.lane_out_valid) begin
      logic [VW-1:0] e;
      for (int l = 0; l < L; l++) e[l*W +: W] = 32'(l + 1 + out_cnt * L);
      chk("lane_out", bus.lane_out, e);
    end
  end

  // Transaction-level timing model: issue decided in cycle c when fewer than D vectors are
  // outstanding or one returns in c; vector appears at c+1, returns at c+1+d; done after last return.
  function automatic int model_done(input int d);
    int t [S];
    int n;
    int c;
    int occ;
    bit popnow;
    n = 0;
    c = 0;
    while (n < S) begin
      occ    = 0;
      popnow = 0;
      for (int j = 0; j < n; j++) begin
        if (t[j] <= c) occ++;
        if (t[j] + d < c) occ--;
        if (t[j] + d == c) popnow = 1;
      end
      if (occ < D || popnow) begin
        t[n] = c + 1;
        n++;
      end
      c++;
    end
    return t[S-1] + d + 1;
  endfunction

  task automatic clear_masks();
    for (int s = 0; s < S; s++) cmask[s] = '0;
  endtask

  task automatic do_run(input string nm, input int d, input bit mid_start, output int dk);
    dly   = d;
    start = 1;
    arm   = 1;
    @(posedge clock);
    #1;
    start = 0;
    arm   = 0;
    chk({nm, ".busy"}, busy, 1);
    chk({nm, ".done_drop"}, done, 0);
    dk = -1;
    for (int k = 1; k < 300; k++) begin
      if (mid_start && k == 2) start = 1;
      @(posedge clock);
      #1;
      start = 0;
      if (done) begin
        dk = k;
        break;
      end
    end
  endtask

  typedef struct {
    int dly;
    int cstep;
    int clane;
    int exp_err;
    int exp_first;
    bit exp_pass;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int   dk;
    int   xe, xf;
    logic [W-1:0] v;

    tbl[0] = '{0, -1, 0, 0, 0, 1};
    tbl[1] = '{0,  2, 1, 1, 1, 0};
    tbl[2] = '{3, -1, 0, 0, 0, 1};
    tbl[3] = '{1,  0, 2, 1, 2, 0};
    tbl[4] = '{2,  5, 0, 1, 0, 0};
    clear_masks();

    repeat (2) @(posedge clock);
    #1;
    chk("rst.lane_out", bus.lane_out, 0);
    chk("rst.valid", bus.lane_out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.err", err_count, 0);
    chk("rst.first", first_err_lane, 0);
    chk("rst.unexp", unexpected, 0);
    reset = 1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 5; i++) begin
      clear_masks();
      if (tbl[i].cstep >= 0) begin
        // XOR with the expected value forces that lane to zero.
        v = 32'((tbl[i].clane + 1) + tbl[i].cstep * L);
        cmask[tbl[i].cstep][tbl[i].clane*W +: W] = v;
      end
      do_run($sformatf("tbl%0d", i), tbl[i].dly, 0, dk);
      chk($sformatf("tbl%0d.cycles", i), dk, model_done(tbl[i].dly));
      chk($sformatf("tbl%0d.err", i), err_count, tbl[i].exp_err);
      chk($sformatf("tbl%0d.first", i), first_err_lane, tbl[i].exp_first);
      chk($sformatf("tbl%0d.pass", i), pass, tbl[i].exp_pass);
      chk($sformatf("tbl%0d.unexp", i), unexpected, 0);
    end

    // Start pulse during a run must be ignored.
    clear_masks();
    do_run("busy_start", 3, 1, dk);
    chk("busy_start.cycles", dk, model_done(3));
    chk("busy_start.pass", pass, 1);

    // Response while DONE sets unexpected and kills pass; next start clears it.
    inj = 1;
    @(posedge clock);
    #1;
    inj = 0;
    chk("unexp.flag", unexpected, 1);
    chk("unexp.pass", pass, 0);
    chk("unexp.done", done, 1);
    do_run("unexp_run", 0, 0, dk);
    chk("unexp_run.unexp", unexpected, 0);
    chk("unexp_run.pass", pass, 1);

    // Reset mid-run at step 2.
    clear_masks();
    cmask[0][2*W +: W] = 32'h5;
    dly   = 0;
    start = 1;
    arm   = 1;
    @(posedge clock);
    #1;
    start = 0;
    arm   = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("midrst.pre_err", err_count, 1);
    chk("midrst.pre_first", first_err_lane, 2);
    reset = 0;
    @(posedge clock);
    #1;
    reset = 1;
    chk("midrst.lane_out", bus.lane_out, 0);
    chk("midrst.valid", bus.lane_out_valid, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.pass", pass, 0);
    chk("midrst.err", err_count, 0);
    chk("midrst.first", first_err_lane, 0);
    chk("midrst.unexp", unexpected, 0);
    clear_masks();
    do_run("midrst_run", 0, 0, dk);
    chk("midrst_run.cycles", dk, model_done(0));
    chk("midrst_run.pass", pass, 1);

`ifdef TABCHK_TIMEOUT_EN
    withhold = 1;
    do_run("tmo", 0, 0, dk);
    withhold = 0;
    chk("tmo.cycles", dk, 9);
    chk("tmo.flag", timed_out, 1);
    chk("tmo.pass", pass, 0);
    do_run("tmo_after", 0, 0, dk);
    chk("tmo_after.flag", timed_out, 0);
    chk("tmo_after.pass", pass, 1);
`endif

    // Randomized latency and corruption against a counting model.
    for (int r = 0; r < 10; r++) begin
      int d;
      int fl;
      d  = $urandom_range(0, 4);
      xe = 0;
      xf = -1;
      clear_masks();
      for (int s = 0; s < S; s++) begin
        if ($urandom_range(0, 2) == 0) begin
          fl = $urandom_range(0, L - 1);
          for (int l = 0; l < L; l++) begin
            if (l == fl || $urandom_range(0, 1) == 1) cmask[s][l*W +: W] = $urandom | 32'd1;
          end
        end
      end
      for (int s = 0; s < S; s++) begin
        if (cmask[s] != '0) begin
          xe++;
          if (xf < 0) begin
            for (int l = L - 1; l >= 0; l--) if (cmask[s][l*W +: W] != '0) xf = l;
          end
        end
      end
      if (xf < 0) xf = 0;
      do_run($sformatf("rnd%0d", r), d, 0, dk);
      chk($sformatf("rnd%0d.cycles", r), dk, model_done(d));
      chk($sformatf("rnd%0d.err", r), err_count, xe);
      chk($sformatf("rnd%0d.first", r), first_err_lane, xf);
      chk($sformatf("rnd%0d.pass", r), pass, (xe == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
